pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS core and the consumer of the control unit's PcSrc decision.
- Owns the PC register and the single-outstanding-request handshake with instruction memory.
- Owns the IF/ID register that feeds the decoder.
- Applies NextIns/Branch/Jump/NOOP redirects: computes targets, squashes wrong-path fetches, holds under ID stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush (sll $0,$0,0).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pc_src  in  2  next-PC select from control unit: `NextIns/`Branch/`Jump/`NOOP
- is_jr  in  1  with pc_src=`Jump, take jr_target instead of jump_index
- br_imm  in  16  branch offset field of the instruction in ID
- jump_index  in  26  J/JAL index field of the instruction in ID
- jr_target  in  32  rs value for JR
- id_stall  in  1  hazard unit: ID cannot accept a new instruction this cycle
- imem_req  out  1  one-cycle request pulse
- imem_addr  out  32  word address of request (= pc)
- imem_rvalid  in  1  response strobe, latency >=1 cycle, at most one outstanding
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  32  IF/ID instruction
- id_pc4  out  32  IF/ID PC+4 of that instruction

Behaviour:
- Reset (async): pc=RESET_PC, state=ISSUE, kill=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc4=0, hold buffer empty.
- State ISSUE:
  - Drive imem_req=1, imem_addr=pc for exactly one cycle, then go to WAIT.
  - No request is issued in a cycle where a redirect is taken; ISSUE repeats next cycle with the new pc.
- State WAIT: imem_rvalid is accepted only in this state; it is ignored in any other state.
  - rvalid && kill: discard the word, kill=0, go to ISSUE.
  - rvalid && !id_stall: IF/ID <= {1, rdata, pc+4}, pc <= pc+4, go to ISSUE.
  - rvalid && id_stall: hold buffer <= rdata, go to HOLD.
- State HOLD: when id_stall falls, IF/ID <= {1, buffer, pc+4}, pc <= pc+4, go to ISSUE.
- ID consumption: when id_valid && !id_stall and nothing new loads, id_valid clears next cycle.
- Redirect condition: id_valid && !id_stall && pc_src in {`Branch,`Jump}. Targets:
  - Branch: id_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00}.
  - Jump, is_jr=0: {id_pc4[31:28], jump_index, 2'b00}.
  - Jump, is_jr=1: jr_target.
- Redirect effects, next edge:
  - pc <= target.
  - IF/ID flushed: id_valid=0, id_instr=NOP_INSTR.
  - In WAIT without rvalid this cycle: kill <= 1, stay WAIT.
  - In WAIT with rvalid this cycle: the response is dropped, go to ISSUE.
  - In HOLD: buffer dropped, go to ISSUE.
  - No branch delay slot.
- Priority: redirect > response load > ID consumption.
- `NOOP (with id_valid): PC and IF/ID freeze for that cycle, identical to id_stall=1.
- `NextIns: no effect beyond normal sequencing.
- pc_src is ignored while id_valid=0.
- Arithmetic: all PC math is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag. Target bits [1:0] are forced to 0.
- Reset mid-WAIT: state returns to ISSUE. The instruction memory shares rst and drops any in-flight response.

Decomposition:
- Shared package (define.v): PcSrc encodings `NextIns=2'b00, `Branch=2'b01, `Jump=2'b10, `NOOP=2'b11. Fetch state encodings FS_ISSUE/FS_WAIT/FS_HOLD. Field macros for the imm/index bit ranges.
- One sub-module: pc_target_gen, purely combinational; computes the branch/jump/jr target from id_pc4, br_imm, jump_index, jr_target, is_jr.

Test Plan:
- Reset + sequential fetch, memory latency 1, no stall: imem_addr sequence 0x0, 0x4, 0x8; id_pc4 0x4, 0x8, 0xC; one request every 2 cycles.
- Branch taken: instruction at 0x10 in ID, pc_src=`Branch, br_imm=16'hFFFE -> next imem_addr=0x0C; IF/ID shows NOP with id_valid=0 for one cycle.
- Jump while fetch outstanding, latency 3:
  - Setup: id_pc4=0x4000_0008, jump_index=26'h0000100, redirect asserted in WAIT.
  - Late response is discarded; next imem_addr=0x4000_0400.
- JR: is_jr=1, jr_target=0x0000_1234 -> imem_addr=0x0000_1234 (bits[1:0] forced 0 -> 0x1234).
- Stall during response: id_stall=1 when rvalid arrives with 0xDEADBEEF -> state HOLD, no new req. Stall drops -> id_instr=0xDEADBEEF, next req at pc+4.
- Async reset asserted in WAIT at pc=0x20: outputs return to reset values immediately; first request after release is at addr 0x0.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared encodings and field widths for the fetch stage.
//   pc_src_e      - next-PC select from the control unit
//   fetch_state_e - fetch FSM states
//   IMM_W/INDEX_W - widths of the branch offset and jump index fields
package pc_fetch_unit_pkg;
    typedef enum logic [1:0] {
        NEXT_INS = 2'b00,
        BRANCH   = 2'b01,
        JUMP     = 2'b10,
        NOOP     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        FS_ISSUE = 2'b00,
        FS_WAIT  = 2'b01,
        FS_HOLD  = 2'b10
    } fetch_state_e;

    localparam int IMM_W   = 16;
    localparam int INDEX_W = 26;

    function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
        return {{14{imm[IMM_W-1]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory request/response channel.
//   req    - one-cycle request pulse (fetch -> memory)
//   addr   - word address of the request (fetch -> memory)
//   rvalid - response strobe, at most one outstanding (memory -> fetch)
//   rdata  - instruction word, valid with rvalid (memory -> fetch)
interface pc_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input rvalid, rdata);
    modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/pc_fetch_unit_target_gen.sv
// pc_target_gen: combinational branch / jump / jr target computation.
//   pc_src, is_jr          - select branch, J/JAL index or JR register target
//   br_imm, jump_index     - instruction fields of the instruction in ID
//   jr_target, id_pc4      - rs value and PC+4 of the instruction in ID
//   target                 - word-aligned redirect address
module pc_target_gen
    import pc_fetch_unit_pkg::*;
(
    input  logic [1:0]         pc_src,
    input  logic               is_jr,
    input  logic [IMM_W-1:0]   br_imm,
    input  logic [INDEX_W-1:0] jump_index,
    input  logic [31:0]        jr_target,
    input  logic [31:0]        id_pc4,
    output logic [31:0]        target
);
    logic [31:0] raw;

    assign raw = (pc_src == JUMP) ? (is_jr ? jr_target : {id_pc4[31:28], jump_index, 2'b00})
                                  : id_pc4 + branch_offset(br_imm);
    assign target = raw & ~32'd3;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS fetch stage - PC, imem handshake and IF/ID register.
//   clk, rst                 - clock, asynchronous active-high reset
//   pc_src, is_jr            - redirect select from control unit
//   br_imm, jump_index       - offset/index fields of the instruction in ID
//   jr_target                - rs value for JR
//   id_stall                 - ID cannot accept a new instruction
//   imem                     - instruction-memory channel (master side)
//   id_valid, id_instr, id_pc4 - IF/ID register
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         pc_src,
    input  logic               is_jr,
    input  logic [IMM_W-1:0]   br_imm,
    input  logic [INDEX_W-1:0] jump_index,
    input  logic [31:0]        jr_target,
    input  logic               id_stall,
    pc_fetch_unit_if.master    imem,
    output logic               id_valid,
    output logic [31:0]        id_instr,
    output logic [31:0]        id_pc4
);
    fetch_state_e state;
    logic [31:0]  pc, pc4, hold_buf, target;
    logic         kill, stall, redirect, load;

    // NOOP with a live instruction in ID behaves exactly like a hazard stall
    assign stall    = id_stall || (id_valid && pc_src == NOOP);
    assign redirect = id_valid && !id_stall && (pc_src == BRANCH || pc_src == JUMP);
    assign pc4      = pc + 32'd4;
    // a response (fresh or held) moves into IF/ID only when ID can take it
    assign load     = !stall && (state == FS_HOLD || (state == FS_WAIT && imem.rvalid && !kill));

    // the request is suppressed in the same cycle a redirect is taken
    assign imem.req  = !rst && state == FS_ISSUE && !redirect;
    assign imem.addr = pc;

    pc_target_gen u_target_gen (
        .pc_src    (pc_src),
        .is_jr     (is_jr),
        .br_imm    (br_imm),
        .jump_index(jump_index),
        .jr_target (jr_target),
        .id_pc4    (id_pc4),
        .target    (target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FS_ISSUE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            hold_buf <= 32'd0;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc4   <= 32'd0;
        end else if (redirect) begin
            pc       <= target;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            // an outstanding request still has to drain; its word is discarded later
            kill     <= state == FS_WAIT && !imem.rvalid;
            state    <= (state == FS_WAIT && !imem.rvalid) ? FS_WAIT : FS_ISSUE;
        end else begin
            if (id_valid && !stall)
                id_valid <= 1'b0;
            if (load) begin
                id_valid <= 1'b1;
                id_instr <= (state == FS_HOLD) ? hold_buf : imem.rdata;
                id_pc4   <= pc4;
                pc       <= pc4;
                state    <= FS_ISSUE;
            end else if (state == FS_ISSUE) begin
                state <= FS_WAIT;
            end else if (state == FS_WAIT && imem.rvalid) begin
                kill     <= 1'b0;
                hold_buf <= imem.rdata;
                state    <= kill ? FS_ISSUE : FS_HOLD;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vector table plus corner-case sequences for pc_fetch_unit.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pc_src;
    logic        is_jr;
    logic [15:0] br_imm;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr, id_pc4;

    int          lat = 1;
    int          cnt;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        pend;
    logic [31:0] paddr;
    logic [31:0] sp_addr = 32'h1;
    logic [31:0] sp_word = 32'h0;

    typedef struct {
        logic [1:0]  src;
        logic [15:0] imm;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl [16];

    pc_fetch_unit_if imem();

    pc_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .pc_src    (pc_src),
        .is_jr     (is_jr),
        .br_imm    (br_imm),
        .jump_index(jump_index),
        .jr_target (jr_target),
        .id_stall  (id_stall),
        .imem      (imem),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc4    (id_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == sp_addr) ? sp_word : (32'hC000_0000 | {8'h00, a[23:0]});
    endfunction

    // instruction memory with programmable latency, reset shared with the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= 1'b0;
            cnt         <= 0;
            paddr       <= 32'd0;
            imem.rvalid <= 1'b0;
            imem.rdata  <= 32'd0;
        end else begin
            imem.rvalid <= 1'b0;
            if (pend && cnt == 1) begin
                imem.rvalid <= 1'b1;
                imem.rdata  <= word(paddr);
                pend        <= 1'b0;
            end else if (pend) begin
                cnt <= cnt - 1;
            end
            if (imem.req) begin
                paddr <= imem.addr;
                if (lat == 1) begin
                    imem.rvalid <= 1'b1;
                    imem.rdata  <= word(imem.addr);
                end else begin
                    pend <= 1'b1;
                    cnt  <= lat - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic outs(input string name, input logic req, input logic [31:0] addr,
                        input logic valid, input logic [31:0] instr, input logic [31:0] pc4);
        chk({name, ".req"},   32'(imem.req), 32'(req));
        chk({name, ".addr"},  imem.addr, addr);
        chk({name, ".valid"}, 32'(id_valid), 32'(valid));
        chk({name, ".instr"}, id_instr, instr);
        chk({name, ".pc4"},   id_pc4, pc4);
    endtask

    task automatic idle();
        pc_src = NEXT_INS; is_jr = 1'b0; br_imm = 16'h0; jump_index = 26'h0;
        jr_target = 32'h0; id_stall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1 outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] src, input logic [15:0] imm, input logic req,
                                input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, input logic [31:0] pc4);
        vec_t v;
        v.src = src; v.imm = imm; v.req = req; v.addr = addr;
        v.valid = valid; v.instr = instr; v.pc4 = pc4;
        return v;
    endfunction

    initial begin
        idle();
        tbl[0]  = mk(NEXT_INS, 16'h0,    1'b1, 32'h00, 1'b0, 32'h0,         32'h00);
        tbl[1]  = mk(NEXT_INS, 16'h0,    1'b0, 32'h00, 1'b0, 32'h0,         32'h00);
        tbl[2]  = mk(NEXT_INS, 16'h0,    1'b1, 32'h04, 1'b1, 32'hC000_0000, 32'h04);
        tbl[3]  = mk(NEXT_INS, 16'h0,    1'b0, 32'h04, 1'b0, 32'hC000_0000, 32'h04);
        tbl[4]  = mk(NEXT_INS, 16'h0,    1'b1, 32'h08, 1'b1, 32'hC000_0004, 32'h08);
        tbl[5]  = mk(NEXT_INS, 16'h0,    1'b0, 32'h08, 1'b0, 32'hC000_0004, 32'h08);
        tbl[6]  = mk(NEXT_INS, 16'h0,    1'b1, 32'h0C, 1'b1, 32'hC000_0008, 32'h0C);
        tbl[7]  = mk(NEXT_INS, 16'h0,    1'b0, 32'h0C, 1'b0, 32'hC000_0008, 32'h0C);
        tbl[8]  = mk(NEXT_INS, 16'h0,    1'b1, 32'h10, 1'b1, 32'hC000_000C, 32'h10);
        tbl[9]  = mk(NEXT_INS, 16'h0,    1'b0, 32'h10, 1'b0, 32'hC000_000C, 32'h10);
        tbl[10] = mk(BRANCH,   16'hFFFE, 1'b0, 32'h14, 1'b1, 32'hC000_0010, 32'h14);
        tbl[11] = mk(NEXT_INS, 16'h0,    1'b1, 32'h0C, 1'b0, 32'h0,         32'h14);
        tbl[12] = mk(NEXT_INS, 16'h0,    1'b0, 32'h0C, 1'b0, 32'h0,         32'h14);
        tbl[13] = mk(NOOP,     16'h0,    1'b1, 32'h10, 1'b1, 32'hC000_000C, 32'h10);
        tbl[14] = mk(NEXT_INS, 16'h0,    1'b0, 32'h10, 1'b1, 32'hC000_000C, 32'h10);
        tbl[15] = mk(NEXT_INS, 16'h0,    1'b1, 32'h14, 1'b1, 32'hC000_0010, 32'h14);

        // sequential fetch, branch back, NOOP freeze (latency 1)
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pc_src = tbl[i].src;
            br_imm = tbl[i].imm;
            #1 outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].instr, tbl[i].pc4);
            @(negedge clk);
        end

        // JR, then jump while a latency-3 fetch is outstanding
        idle();
        do_reset();
        @(negedge clk); @(negedge clk);
        pc_src = JUMP; is_jr = 1'b1; jr_target = 32'h0000_1234;
        #1 chk("jr.req_suppressed", 32'(imem.req), 32'd0);
        @(negedge clk);
        idle();
        #1 outs("jr.target", 1'b1, 32'h0000_1234, 1'b0, 32'h0, 32'h4);
        @(negedge clk); @(negedge clk);
        pc_src = JUMP; is_jr = 1'b1; jr_target = 32'h4000_0005;
        #1 chk("jr2.pc4", id_pc4, 32'h0000_1238);
        lat = 3;
        @(negedge clk);
        idle();
        #1 chk("jr2.addr", imem.addr, 32'h4000_0004);
        repeat (4) @(negedge clk);
        pc_src = NOOP;
        #1 outs("j.setup", 1'b1, 32'h4000_0008, 1'b1, 32'hC000_0004, 32'h4000_0008);
        @(negedge clk);
        pc_src = JUMP; is_jr = 1'b0; jump_index = 26'h0000100;
        #1 outs("j.in_wait", 1'b0, 32'h4000_0008, 1'b1, 32'hC000_0004, 32'h4000_0008);
        @(negedge clk);
        idle();
        #1 outs("j.flushed", 1'b0, 32'h4000_0400, 1'b0, 32'h0, 32'h4000_0008);
        @(negedge clk);
        #1 chk("j.late_resp.valid", 32'(id_valid), 32'd0);
        @(negedge clk);
        #1 outs("j.reissue", 1'b1, 32'h4000_0400, 1'b0, 32'h0, 32'h4000_0008);
        repeat (4) @(negedge clk);
        #1 outs("j.loaded", 1'b1, 32'h4000_0404, 1'b1, 32'hC000_0400, 32'h4000_0404);

        // stall while the response arrives, then release from HOLD
        lat = 1; sp_addr = 32'h4; sp_word = 32'hDEAD_BEEF;
        idle();
        do_reset();
        @(negedge clk); @(negedge clk);
        #1 chk("st.first.pc4", id_pc4, 32'h4);
        @(negedge clk);
        id_stall = 1'b1;
        #1 chk("st.resp.req", 32'(imem.req), 32'd0);
        @(negedge clk);
        #1 outs("st.hold", 1'b0, 32'h4, 1'b0, 32'hC000_0000, 32'h4);
        @(negedge clk);
        #1 chk("st.hold2.req", 32'(imem.req), 32'd0);
        @(negedge clk);
        id_stall = 1'b0;
        #1 chk("st.release.req", 32'(imem.req), 32'd0);
        @(negedge clk);
        #1 outs("st.loaded", 1'b1, 32'h8, 1'b1, 32'hDEAD_BEEF, 32'h8);
        sp_addr = 32'h1;

        // async reset while waiting at pc=0x20
        idle();
        do_reset();
        @(negedge clk); @(negedge clk);
        pc_src = JUMP; is_jr = 1'b1; jr_target = 32'h20;
        @(negedge clk);
        idle();
        lat = 3;
        #1 chk("rw.addr", imem.addr, 32'h20);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 outs("rw.async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 outs("rw.first", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1 chk("rw.c1.valid", 32'(id_valid), 32'd0);
        @(negedge clk);
        #1 chk("rw.c2.valid", 32'(id_valid), 32'd0);
        @(negedge clk); @(negedge clk);
        #1 outs("rw.loaded", 1'b1, 32'h4, 1'b1, 32'hC000_0000, 32'h4);

        // 32-bit wrap, forced alignment, forward branch
        lat = 1;
        idle();
        do_reset();
        @(negedge clk); @(negedge clk);
        pc_src = JUMP; is_jr = 1'b1; jr_target = 32'hFFFF_FFFF;
        @(negedge clk);
        idle();
        #1 chk("wr.addr", imem.addr, 32'hFFFF_FFFC);
        @(negedge clk); @(negedge clk);
        pc_src = BRANCH; br_imm = 16'h0003;
        #1 outs("wr.wrap", 1'b0, 32'h0, 1'b1, 32'hC0FF_FFFC, 32'h0);
        @(negedge clk);
        idle();
        #1 chk("wr.fwd_branch", imem.addr, 32'h0000_000C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
